// File: rtl/instr_exec_ctrl_pkg.sv
`default_nettype none
// instr_register_pkg: shared types for the instruction register and its execution sequencer.
// Revision: 1.0
package instr_register_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W:0] MAX_INSTR = 6'd32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [DATA_W-1:0]   operand_t;
  typedef logic signed [2*DATA_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_RESP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_exec_ctrl_if.sv
`default_nettype none
// instr_exec_ctrl_if: run control, register read port and result handshake of the sequencer.
// Revision: 1.0
interface instr_exec_ctrl_if;
  import instr_register_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W:0]     num_instr;
  logic                abort;
  logic [ADDR_W-1:0]   read_pointer;
  instruction_t        instruction_word;
  logic                res_valid;
  logic                res_ready;
  logic [ADDR_W-1:0]   res_addr;
  opcode_t             res_opc;
  result_t             result;
  logic                err_div0;
  logic                busy;
  logic                done;

  modport master (
    input  start, start_addr, num_instr, abort, instruction_word, res_ready,
    output read_pointer, res_valid, res_addr, res_opc, result, err_div0, busy, done
  );

  modport slave (
    output start, start_addr, num_instr, abort, instruction_word, res_ready,
    input  read_pointer, res_valid, res_addr, res_opc, result, err_div0, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/instr_exec_ctrl_alu.sv
`default_nettype none
// instr_alu: combinational signed ALU on one instruction word, result widened to 2*DATA_W.
// Revision: 1.0
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t i_iw,
  output result_t      o_result,
  output logic         o_err_div0
);

  result_t w_a;
  result_t w_b;

  // Operate at full result width so MULT keeps every bit and DIV of -2^31 by -1 cannot overflow.
  assign w_a = {{DATA_W{i_iw.op_a[DATA_W-1]}}, i_iw.op_a};
  assign w_b = {{DATA_W{i_iw.op_b[DATA_W-1]}}, i_iw.op_b};

  always_comb begin
    o_result   = '0;
    o_err_div0 = 1'b0;
    case (i_iw.opc)
      ZERO:  o_result = '0;
      PASSA: o_result = w_a;
      PASSB: o_result = w_b;
      ADD:   o_result = w_a + w_b;
      SUB:   o_result = w_a - w_b;
      MULT:  o_result = w_a * w_b;
      DIV: begin
        if (w_b == '0) o_err_div0 = 1'b1;
        else           o_result   = w_a / w_b;
      end
      MOD: begin
        if (w_b == '0) o_err_div0 = 1'b1;
        else           o_result   = w_a % w_b;
      end
      default: o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_exec_ctrl.sv
`default_nettype none
// instr_exec_ctrl: walks a window of the instruction register, executes each word and
// hands one result per instruction downstream over valid/ready. Revision: 1.0
module instr_exec_ctrl
  import instr_register_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  instr_exec_ctrl_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   w_sat_n;
  instruction_t      r_iw;
  result_t           r_result;
  opcode_t           r_res_opc;
  logic [ADDR_W-1:0] r_res_addr;
  logic              r_err_div0;
  logic              r_res_valid;
  result_t           w_alu_result;
  logic              w_alu_err;
  logic              w_accept;

  assign w_sat_n  = (bus.num_instr > MAX_INSTR) ? MAX_INSTR : bus.num_instr;
  assign w_accept = bus.start && !bus.abort;

  instr_alu u_alu (
    .i_iw       (r_iw),
    .o_result   (w_alu_result),
    .o_err_div0 (w_alu_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_sat_n == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (bus.res_ready) w_next = (r_remaining == 1) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_iw        <= '0;
      r_result    <= '0;
      r_res_opc   <= ZERO;
      r_res_addr  <= '0;
      r_err_div0  <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (bus.abort) begin
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_remaining <= w_sat_n;
            // The read pointer only moves when a fetch will actually follow.
            if (w_sat_n != '0) r_addr <= bus.start_addr;
          end
        end
        S_FETCH: r_iw <= bus.instruction_word;
        S_EXEC: begin
          r_result    <= w_alu_result;
          r_res_opc   <= r_iw.opc;
          r_res_addr  <= r_addr;
          r_err_div0  <= w_alu_err;
          r_res_valid <= 1'b1;
        end
        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining != 1) r_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.read_pointer = r_addr;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_addr     = r_res_addr;
  assign bus.res_opc      = r_res_opc;
  assign bus.result       = r_result;
  assign bus.err_div0     = r_err_div0;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_exec_ctrl.sv
`default_nettype none
// tb_instr_exec_ctrl: directed runs with a queue scoreboard checked by a separate monitor.
// Revision: 1.0
module tb_instr_exec_ctrl;
  import instr_register_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    opcode_t           opc;
    result_t           res;
    logic              err;
  } exp_t;

  logic         clk;
  logic         reset_n;
  instruction_t mem [32];
  exp_t         q[$];
  int           checks;
  int           errors;

  instr_exec_ctrl_if bus();

  instr_exec_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.instruction_word = mem[bus.read_pointer];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input opcode_t opc, input operand_t x, input operand_t y);
    mem[a].opc  = opc;
    mem[a].op_a = x;
    mem[a].op_b = y;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input opcode_t opc, input result_t r, input logic e);
    exp_t t;
    t.addr = a; t.opc = opc; t.res = r; t.err = e;
    q.push_back(t);
  endtask

  // Returns in cycle 1 of the run (the first cycle after start is sampled).
  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.num_instr  = n;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int exp_c, input string name);
    int c;
    c = c0;
    while (!bus.done && c < 200) begin
      tick();
      c++;
    end
    chk({name, "_done_seen"}, 64'(bus.done), 64'd1);
    chk({name, "_done_cycle"}, 64'(c), 64'(exp_c));
  endtask

  // Monitor: a transfer happens on the coming edge when valid && ready and no abort.
  always @(negedge clk) begin
    if (reset_n && bus.res_valid && bus.res_ready && !bus.abort) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(bus.res_addr), 64'h0bad);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_addr", 64'(bus.res_addr), 64'(e.addr));
        chk("res_opc",  64'(bus.res_opc),  64'(e.opc));
        chk("result",   bus.result,        e.res);
        chk("err_div0", 64'(bus.err_div0), 64'(e.err));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.num_instr  = '0;
    bus.abort      = 1'b0;
    bus.res_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_busy",  64'(bus.busy),      64'd0);
    chk("rst_done",  64'(bus.done),      64'd0);
    chk("rst_rdptr", 64'(bus.read_pointer), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    reset_n = 1'b1;
    tick();

    // Single ADD; a start during the run must be ignored.
    load(3, ADD, -32'sd5, 32'sd7);
    push(5'd3, ADD, 64'sd2, 1'b0);
    do_start(5'd3, 6'd1);
    chk("t1_busy_c1", 64'(bus.busy), 64'd1);
    chk("t1_rdptr",   64'(bus.read_pointer), 64'd3);
    tick();
    bus.start = 1'b1; bus.start_addr = 5'd9; bus.num_instr = 6'd5;
    tick();
    bus.start = 1'b0;
    wait_done(3, 4, "t1");
    tick();
    chk("t1_busy_after", 64'(bus.busy), 64'd0);
    chk("t1_done_after", 64'(bus.done), 64'd0);

    // Address wrap 30 -> 31 -> 0.
    load(30, MULT, -32'sd4, 32'sd15);
    load(31, SUB,  32'sd2,  32'sd9);
    load(0,  PASSB, 32'sd99, 32'sd11);
    push(5'd30, MULT, -64'sd60, 1'b0);
    push(5'd31, SUB,  -64'sd7,  1'b0);
    push(5'd0,  PASSB, 64'sd11, 1'b0);
    do_start(5'd30, 6'd3);
    wait_done(1, 10, "t2");
    tick();

    // Division, modulo, divide-by-zero and wide products.
    load(5,  DIV,  -32'sd7, 32'sd2);
    load(6,  MOD,  -32'sd7, 32'sd2);
    load(7,  DIV,  32'sd9,  32'sd0);
    load(8,  MOD,  32'sd5,  32'sd0);
    load(9,  ZERO, 32'sd4,  32'sd4);
    load(10, PASSA, -32'sd8, 32'sd1);
    load(11, MULT, 32'sh7fffffff, 32'sh7fffffff);
    load(12, DIV,  32'sh80000000, -32'sd1);
    push(5'd5,  DIV,  -64'sd3, 1'b0);
    push(5'd6,  MOD,  -64'sd1, 1'b0);
    push(5'd7,  DIV,  64'sd0,  1'b1);
    push(5'd8,  MOD,  64'sd0,  1'b1);
    push(5'd9,  ZERO, 64'sd0,  1'b0);
    push(5'd10, PASSA, -64'sd8, 1'b0);
    push(5'd11, MULT, 64'sh3fffffff00000001, 1'b0);
    push(5'd12, DIV,  64'sd2147483648, 1'b0);
    do_start(5'd5, 6'd8);
    wait_done(1, 25, "t3");
    tick();

    // Backpressure: five stalled cycles, then release.
    load(15, ADD, 32'sd100, 32'sd23);
    load(16, SUB, 32'sd1,   32'sd2);
    push(5'd15, ADD, 64'sd123, 1'b0);
    push(5'd16, SUB, -64'sd1,  1'b0);
    bus.res_ready = 1'b0;
    do_start(5'd15, 6'd2);
    c = 1;
    while (!bus.res_valid && c < 10) begin
      tick();
      c++;
    end
    chk("t4_latency", 64'(c), 64'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_valid",  64'(bus.res_valid), 64'd1);
      chk("t4_stall_result", bus.result,          64'd123);
      chk("t4_stall_addr",   64'(bus.res_addr),   64'd15);
    end
    bus.res_ready = 1'b1;
    wait_done(8, 12, "t4");
    tick();

    // Abort during a stall, with ready raised in the same cycle.
    load(20, ADD, 32'sd1, 32'sd1);
    bus.res_ready = 1'b0;
    do_start(5'd20, 6'd1);
    repeat (3) tick();
    chk("t5_valid_pre", 64'(bus.res_valid), 64'd1);
    bus.abort = 1'b1; bus.res_ready = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_valid_post", 64'(bus.res_valid), 64'd0);
    chk("t5_busy_post",  64'(bus.busy),      64'd0);
    chk("t5_done_post",  64'(bus.done),      64'd0);
    tick();
    chk("t5_done_later", 64'(bus.done), 64'd0);
    bus.start = 1'b1; bus.abort = 1'b1; bus.num_instr = 6'd1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("t5_start_abort_busy", 64'(bus.busy), 64'd0);
    do_start(5'd7, 6'd0);
    chk("t5_n0_done", 64'(bus.done), 64'd1);
    chk("t5_n0_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("t5_n0_done_end", 64'(bus.done), 64'd0);
    chk("t5_n0_busy_end", 64'(bus.busy), 64'd0);

    // Asynchronous reset in EXEC.
    load(25, ADD, 32'sd3, 32'sd4);
    do_start(5'd25, 6'd1);
    tick();
    chk("t6_pre_result", bus.result, 64'd2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy",   64'(bus.busy),         64'd0);
    chk("t6_rst_valid",  64'(bus.res_valid),    64'd0);
    chk("t6_rst_rdptr",  64'(bus.read_pointer), 64'd0);
    chk("t6_rst_result", bus.result,            64'd0);
    chk("t6_rst_addr",   64'(bus.res_addr),     64'd0);
    chk("t6_rst_opc",    64'(bus.res_opc),      64'(ZERO));
    chk("t6_rst_err",    64'(bus.err_div0),     64'd0);
    chk("t6_rst_done",   64'(bus.done),         64'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t6_idle_busy",  64'(bus.busy),      64'd0);
    chk("t6_idle_valid", 64'(bus.res_valid), 64'd0);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_exec_ctrl.md
# instr_exec_ctrl

Sequencer that drains the instruction register: on `start` it walks `read_pointer` through a programmed window of register locations, fetches each `instruction_word`, executes its opcode on the operands, and presents one result per instruction to a downstream consumer over a valid/ready handshake. It sits between `instr_register`, whose read port it owns, and the result scoreboard/consumer, which applies backpressure. Division faults are flagged per result, and a sync `abort` lets the host cancel a run.

## Interface
- `ADDR_W`, 5, register-file address width (32 locations)
- `DATA_W`, 32, signed operand width; result is 2*`DATA_W`
- `clk` in 1: single clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a run (sampled in IDLE only)
- `start_addr` in `ADDR_W`: first location to execute
- `num_instr` in `ADDR_W`+1: instructions in run; values >32 saturate to 32
- `abort` in 1: synchronous cancel of the current run
- `read_pointer` out `ADDR_W`: read address to `instr_register`
- `instruction_word` in `instruction_t`: combinational read data (`opc`, `op_a`, `op_b`)
- `res_valid` out 1: result available
- `res_ready` in 1: consumer accepts result
- `res_addr` out `ADDR_W`: location the result came from
- `res_opc` out `opcode_t`: opcode executed
- `result` out 2*`DATA_W` signed: computed value
- `err_div0` out 1: DIV/MOD with `op_b`==0, qualified by `res_valid`
- `busy` out 1: high in any state except IDLE
- `done` out 1: one-cycle pulse at normal run completion

## Operation
- FSM states: IDLE, FETCH, EXEC, RESP, DONE.
- IDLE: `start`=1 latches `start_addr` into addr and the saturated `num_instr` into remaining. Next state is FETCH, or DONE if `num_instr`==0.
- FETCH: `read_pointer`=addr. Capture `instruction_word` into the iw register at the edge.
- EXEC: compute the ALU result from captured iw. Register `result`, `res_opc`, `res_addr`, `err_div0`. Set `res_valid` at the edge and go to RESP.
- RESP: hold all result outputs stable while `res_valid`=1 and `res_ready`=0. On `res_ready`=1, clear `res_valid` and decrement remaining. If remaining becomes 0, go to DONE. Otherwise addr = addr+1 mod 32 (31 wraps to 0) and go to FETCH.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `abort`=1 in FETCH/EXEC/RESP/DONE: go to IDLE next edge and clear `res_valid`. `done` is not pulsed; an in-flight result is discarded. `abort` has priority over `res_ready`.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `abort` wins, stay IDLE.
- ALU (signed, sign-extended to 2*`DATA_W`):
  - ZERO→0, PASSA→a, PASSB→b
  - ADD→a+b, SUB→a−b, MULT→a*b (full product, no overflow)
  - DIV→a/b truncated toward zero; MOD→a%b, sign of dividend
  - DIV/MOD with b==0: `result`=0, `err_div0`=1. All other ops: `err_div0`=0.
- `read_pointer` holds its last value outside FETCH.

## Timing
- Reset values: state IDLE, `read_pointer`=0, `res_valid`=0, `result`=0, `res_addr`=0, `res_opc`=ZERO, `err_div0`=0, `busy`=0, `done`=0.
- Reset asserted mid-run returns to IDLE immediately; no `done`.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- Latency: FETCH entered at cycle N gives `res_valid`=1 from cycle N+2.
- Throughput with `res_ready` tied high: 3 cycles per instruction. Run of k instructions: `done` at cycle 3k+1 after `start`.
- Handshake: a transfer occurs on an edge with `res_valid` && `res_ready`. `res_ready` may be high before valid. Stalls are unbounded.

## Structure
- `instr_register_pkg` gains `result_t` (signed 2*`DATA_W`) and the FSM state enum. It already holds `opcode_t`, `operand_t` and `instruction_t`.
- Combinational sub-module `instr_alu` (iw in; result and `err_div0` out) is shared with the scoreboard reference model.

## Test plan
- Load loc 3 with ADD a=−5 b=7. `start` at addr 3, n=1, ready high: result 2 at `res_addr` 3 on cycle 3, `done` at cycle 4.
- Locs 30,31,0 hold MULT (−4,15), SUB (2,9), PASSB (_,11). Start at 30, n=3: results −60, −7, 11; addresses 30, 31, 0 (wrap).
- DIV a=−7 b=2 → −3. MOD a=−7 b=2 → −1. DIV a=9 b=0 → `result` 0, `err_div0`=1.
- Hold `res_ready` low 5 cycles in RESP: outputs stay stable. Raise `res_ready`: single transfer and run continues.
- `abort` during a RESP stall: IDLE next cycle, `res_valid` 0, no `done`. A following `start` with n=0 gives `done` 1 cycle later with no results.
- Assert `reset_n` low mid-EXEC: all outputs take reset values immediately. `start` while busy has no effect.
